// File: rtl/hazard_control_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : hazard_control_unit_pkg                                            |
// | Brief  : Forwarding-select codes and FSM state encoding for the hazard unit |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
package hazard_control_unit_pkg;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_EX  = 2'b01;
  localparam logic [1:0] c_FWD_MEM = 2'b10;
  localparam logic [1:0] c_FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_fwd_select.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : fwd_select                                                         |
// | Brief  : Per-operand forwarding mux select from the shadow EX/MEM/WB stages |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module fwd_select #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_we,
  input  logic             i_ex_load,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_we,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_we,
  output logic [1:0]       o_sel
);
  import hazard_control_unit_pkg::*;

  localparam logic [REG_W-1:0] c_PC = REG_W'(PC_REG);

  logic w_active;
  assign w_active = i_use && (i_src != c_PC);

  // Youngest producer wins; a load still in EX has no data yet, so it never selects EX.
  always_comb begin
    o_sel = c_FWD_RF;
    if (w_active) begin
      if (i_ex_we && !i_ex_load && (i_ex_rd == i_src))
        o_sel = c_FWD_EX;
      else if (i_mem_we && (i_mem_rd == i_src))
        o_sel = c_FWD_MEM;
      else if (i_wb_we && (i_wb_rd == i_src))
        o_sel = c_FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : hazard_control_unit                                                |
// | Brief  : 5-stage pipeline sequencer: stalls, branch flush, operand forwarding|
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module hazard_control_unit #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             id_use_d,
  input  logic             id_rf_en,
  input  logic             id_load,
  input  logic             ex_branch,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             if_id_flush,
  output logic             nop_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_d,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import hazard_control_unit_pkg::*;

  localparam logic [REG_W-1:0] c_PC      = REG_W'(PC_REG);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [REG_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
  logic             r_ex_we, r_ex_load, r_mem_we, r_wb_we;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_load_use, w_pc_le, w_if_id_le, w_flush, w_nop, w_stall_inc, w_flush_inc;

  assign w_load_use = r_ex_load && r_ex_we && (r_ex_rd != c_PC) &&
                      ((id_use_a && (id_ra == r_ex_rd)) ||
                       (id_use_b && (id_rb == r_ex_rd)) ||
                       (id_use_d && (id_rd == r_ex_rd)));

  always_comb begin
    w_pc_le     = 1'b1;
    w_if_id_le  = 1'b1;
    w_flush     = 1'b0;
    w_nop       = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    w_state_nxt = S_RUN;
    case (r_state)
      // FLUSH squashes the wrong-path slot; EX holds a bubble so ex_branch is meaningless here.
      S_BOOT, S_FLUSH: w_nop = 1'b1;
      default: begin
        if (ex_branch) begin
          w_flush     = 1'b1;
          w_nop       = 1'b1;
          w_flush_inc = 1'b1;
          w_state_nxt = S_FLUSH;
        end else if (w_load_use) begin
          w_pc_le     = 1'b0;
          w_if_id_le  = 1'b0;
          w_nop       = 1'b1;
          w_stall_inc = 1'b1;
          w_state_nxt = S_STALL;
        end
      end
    endcase
  end

  // While reset is held the control outputs sit at their safe values, independent of the clock.
  assign pc_le       = reset & w_pc_le;
  assign if_id_le    = reset & w_if_id_le;
  assign if_id_flush = ~reset | w_flush;
  assign nop_sel     = ~reset | w_nop;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_BOOT;
      r_ex_rd     <= '0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_we    <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_we     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wb_rd   <= r_mem_rd;
      r_wb_we   <= r_mem_we;
      r_mem_rd  <= r_ex_rd;
      r_mem_we  <= r_ex_we;
      r_ex_rd   <= w_nop ? '0 : id_rd;
      r_ex_we   <= w_nop ? 1'b0 : id_rf_en;
      r_ex_load <= w_nop ? 1'b0 : id_load;
      if (w_stall_inc && (r_stall_cnt != c_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != c_CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_a (
    .i_src(id_ra), .i_use(id_use_a),
    .i_ex_rd(r_ex_rd), .i_ex_we(r_ex_we), .i_ex_load(r_ex_load),
    .i_mem_rd(r_mem_rd), .i_mem_we(r_mem_we),
    .i_wb_rd(r_wb_rd), .i_wb_we(r_wb_we),
    .o_sel(fwd_a)
  );

  fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_b (
    .i_src(id_rb), .i_use(id_use_b),
    .i_ex_rd(r_ex_rd), .i_ex_we(r_ex_we), .i_ex_load(r_ex_load),
    .i_mem_rd(r_mem_rd), .i_mem_we(r_mem_we),
    .i_wb_rd(r_wb_rd), .i_wb_we(r_wb_we),
    .o_sel(fwd_b)
  );

  fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_d (
    .i_src(id_rd), .i_use(id_use_d),
    .i_ex_rd(r_ex_rd), .i_ex_we(r_ex_we), .i_ex_load(r_ex_load),
    .i_mem_rd(r_mem_rd), .i_mem_we(r_mem_we),
    .i_wb_rd(r_wb_rd), .i_wb_we(r_wb_we),
    .o_sel(fwd_d)
  );

endmodule
`default_nettype wire
